fifo_push_arbiter: RTL and testbench
====================================

// Module: fifo_push_arbiter
// PURPOSE
//  Round-robin arbiter that shares the push side of one FIFO between NUM_REQ
//  producers using a valid/ready handshake. A granted producer owns the port
//  for a burst of up to BURST_LEN words, then priority rotates.
//  Sits directly in front of the FIFO data_input/push/full_out ports.
// PARAMETERS
//  WORDLENGHT  8  data word width, equal to the FIFO word width
//  NUM_REQ     4  number of producers (>=2)
//  BURST_LEN   4  max words accepted per grant (>=1)
// PORTS
//  clk          in   1                    clock, all state on rising edge
//  reset        in   1                    asynchronous, active-high reset
//  synch_rst    in   1                    synchronous clear, same effect as reset
//  req_valid    in   NUM_REQ              producer i has a word on req_data slice i
//  req_data     in   NUM_REQ*WORDLENGHT   packed words, slice i = [i*W +: W]
//  req_ready    out  NUM_REQ              word of producer i is accepted this cycle
//  fifo_full    in   1                    from FIFO full_out
//  fifo_push    out  1                    to FIFO push
//  fifo_data    out  WORDLENGHT           to FIFO data_input
//  grant_valid  out  1                    high while in BURST
//  grant_id     out  CeilLog2(NUM_REQ)    current owner; holds last owner in IDLE
// BEHAVIOUR
//  Reset (async or synch_rst): state=IDLE, rr_ptr=0, beat_cnt=0, grant_id=0.
//   Outputs after reset: grant_valid=0, req_ready=0, fifo_push=0, fifo_data=0.
//   synch_rst wins over every other event. In the synch_rst cycle fifo_push=0
//   and req_ready=0.
//  Registered state: state{IDLE,BURST}, rr_ptr, grant_id, beat_cnt.
//   beat_cnt is CeilLog2(BURST_LEN+1) bits wide.
//  IDLE: all outputs 0 except grant_id.
//   If any req_valid=1: grant_id <= the first i with req_valid[i]=1, searching
//   rr_ptr, rr_ptr+1, ... mod NUM_REQ. Also beat_cnt<=0 and state<=BURST.
//   Arbitration costs exactly 1 IDLE cycle; the first push comes 1 cycle later.
//  BURST (g=grant_id): combinational outputs.
//   - req_ready[g] = ~fifo_full; all other ready bits are 0.
//   - fifo_push = req_valid[g] & ~fifo_full.
//   - fifo_data = req_data slice g; it is 0 when fifo_push=0.
//   - Each push increments beat_cnt.
//   - Exit to IDLE when a push occurs with beat_cnt==BURST_LEN-1, or when
//     req_valid[g]=0 (no push that cycle).
//   - On exit: rr_ptr <= (g+1) mod NUM_REQ (wrap from NUM_REQ-1 to 0).
//  Full: while fifo_full=1 in BURST, stay in BURST with no push.
//   beat_cnt and grant hold; there is no timeout.
//  A producer must hold req_valid and its data stable until ready; dropping
//   valid releases the grant.
//  Back-to-back grants always have one IDLE cycle between them
//   (peak throughput BURST_LEN words per BURST_LEN+1 cycles).
//  Non-granted producers never see ready=1, so no word is lost or duplicated.
// TESTING (NUM_REQ=4, BURST_LEN=4, FIFO depth 8)
//  1. Only producer 2 valid, data 0x10..0x15 -> IDLE, grant 2, pushes
//     0x10-0x13, IDLE, grant 2 again, pushes 0x14,0x15, then releases.
//  2. All four valid continuously -> grant order 0,1,2,3,0; exactly 4 pushes
//     per grant; FIFO reaches full after 8 words.
//  3. fifo_full=1 for 3 cycles mid-burst after 2 beats -> fifo_push=0 and
//     ready=0 for those cycles; burst resumes and ends after 4 total pushes.
//  4. Producer 3 granted drops valid after 1 beat, producer 0 valid -> IDLE,
//     then grant 0 (rr_ptr wrapped to 0).
//  5. Assert synch_rst in BURST with beat_cnt=2 -> no push that cycle; next
//     cycle IDLE, rr_ptr=0; the next grant goes to the lowest valid id.
//  6. Async reset pulse mid-burst between clock edges -> outputs go to 0
//     immediately; the FIFO sees no push until re-arbitration.

Source files
------------

// File: rtl/fifo_push_arbiter.sv
// Round-robin arbiter sharing the push side of a single FIFO between NUM_REQ
// producers that use a valid/ready handshake. A granted producer owns the FIFO
// port for a burst of up to BURST_LEN words, then priority rotates to the next
// producer after it.
//
// Ports
//   clk          clock, all state on the rising edge
//   reset        asynchronous active-high reset
//   synch_rst    synchronous clear, same effect as reset, wins over everything
//   req_valid    per-producer valid
//   req_data     packed producer words, slice i = [i*WORDLENGHT +: WORDLENGHT]
//   req_ready    per-producer accept strobe (only the owner can see it high)
//   fifo_full    FIFO full flag
//   fifo_push    FIFO push strobe
//   fifo_data    FIFO write data (zero when not pushing)
//   grant_valid  high while a producer owns the port
//   grant_id     current owner; holds the last owner while idle
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no owner; arbitrate among valid producers starting at rr_ptr
// BURST | grant_id owns the FIFO port until BURST_LEN pushes or valid drops

module fifo_push_arbiter #(
   parameter int WORDLENGHT = 8,
   parameter int NUM_REQ    = 4,
   parameter int BURST_LEN  = 4
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            synch_rst,
   input  logic [NUM_REQ-1:0]              req_valid,
   input  logic [NUM_REQ*WORDLENGHT-1:0]   req_data,
   output logic [NUM_REQ-1:0]              req_ready,
   input  logic                            fifo_full,
   output logic                            fifo_push,
   output logic [WORDLENGHT-1:0]           fifo_data,
   output logic                            grant_valid,
   output logic [$clog2(NUM_REQ)-1:0]      grant_id
);

   localparam int ID_W  = $clog2(NUM_REQ);
   localparam int CNT_W = $clog2(BURST_LEN + 1);

   typedef enum logic {IDLE, BURST} state_t;

   state_t             state;
   logic [ID_W-1:0]    rr_ptr;
   logic [CNT_W-1:0]   beat_cnt;

   logic               g_valid;
   logic [WORDLENGHT-1:0] g_data;
   logic               in_burst;
   logic               accept;
   logic               push;
   logic               last_beat;
   logic [ID_W-1:0]    next_rr;
   logic [ID_W-1:0]    pick;
   logic               found;

   // Mux the owner's valid and data out of the packed request vectors.
   always_comb begin
      g_valid = 1'b0;
      g_data  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant_id == ID_W'(i)) begin
            g_valid = req_valid[i];
            g_data  = req_data[i*WORDLENGHT +: WORDLENGHT];
         end
      end
   end

   // Rotating search: first valid producer at or after rr_ptr, wrapping.
   always_comb begin
      int idx;
      idx   = 0;
      pick  = rr_ptr;
      found = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = int'(rr_ptr) + k;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (!found && req_valid[idx]) begin
            found = 1'b1;
            pick  = ID_W'(idx);
         end
      end
   end

   assign in_burst  = (state == BURST);
   // synch_rst suppresses the handshake in its own cycle so no word is
   // accepted by a producer while the arbiter is being cleared.
   assign accept    = in_burst & ~fifo_full & ~synch_rst;
   assign push      = accept & g_valid;
   assign last_beat = (beat_cnt == CNT_W'(BURST_LEN - 1));
   assign next_rr   = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);

   always_comb begin
      req_ready = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         req_ready[i] = accept & (grant_id == ID_W'(i));
      end
   end

   assign fifo_push   = push;
   assign fifo_data   = push ? g_data : '0;
   assign grant_valid = in_burst;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         rr_ptr   <= '0;
         beat_cnt <= '0;
         grant_id <= '0;
      end else if (synch_rst) begin
         state    <= IDLE;
         rr_ptr   <= '0;
         beat_cnt <= '0;
         grant_id <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (|req_valid) begin
                  grant_id <= pick;
                  beat_cnt <= '0;
                  state    <= BURST;
               end
            end
            BURST: begin
               if (push) begin
                  beat_cnt <= beat_cnt + CNT_W'(1);
                  if (last_beat) begin
                     state  <= IDLE;
                     rr_ptr <= next_rr;
                  end
               end else if (!g_valid) begin
                  // Owner dropped valid: release even while the FIFO is full.
                  state  <= IDLE;
                  rr_ptr <= next_rr;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_push_arbiter.sv
module tb_fifo_push_arbiter;

   localparam int W  = 8;
   localparam int N  = 4;
   localparam int BL = 4;

   logic           clk = 1'b0;
   logic           reset;
   logic           synch_rst;
   logic [N-1:0]   req_valid;
   logic [N*W-1:0] req_data;
   logic [N-1:0]   req_ready;
   logic           fifo_full;
   logic           fifo_push;
   logic [W-1:0]   fifo_data;
   logic           grant_valid;
   logic [1:0]     grant_id;

   always #5 clk = ~clk;

   fifo_push_arbiter #(.WORDLENGHT(W), .NUM_REQ(N), .BURST_LEN(BL)) dut (
      .clk(clk), .reset(reset), .synch_rst(synch_rst),
      .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
      .fifo_full(fifo_full), .fifo_push(fifo_push), .fifo_data(fifo_data),
      .grant_valid(grant_valid), .grant_id(grant_id)
   );

   int n_vec = 0;
   int n_err = 0;

   // Reference model: owner (-1 when idle), shown grant id, words in the
   // current burst and a priority queue whose head is searched first.
   int m_owner;
   int m_gid;
   int m_words;
   int prio[$];

   logic [W-1:0] prod_word [N];
   int   push_cnt;
   int   grants[$];
   logic prev_gv;
   bit   fifo_model_en;
   int   fifo_occ;

   typedef struct {
      logic [3:0]  v;
      logic        f;
      logic        s;
      logic [15:0] exp;
   } vec_t;
   vec_t tbl [10];

   function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endfunction

   function automatic void model_reset();
      m_owner = -1;
      m_gid   = 0;
      m_words = 0;
      prio.delete();
      for (int i = 0; i < N; i++) prio.push_back(i);
   endfunction

   // Expected {req_ready, fifo_push, fifo_data, grant_valid, grant_id}.
   function automatic logic [15:0] model_out(logic [3:0] v, logic f, logic s);
      logic [3:0] rd;
      logic       p;
      logic [7:0] d;
      rd = '0; p = 1'b0; d = '0;
      if (m_owner >= 0 && !s) begin
         rd[m_owner] = ~f;
         p = v[m_owner] & ~f;
         if (p) d = prod_word[m_owner];
      end
      return {rd, p, d, (m_owner >= 0) ? 1'b1 : 1'b0, 2'(m_gid)};
   endfunction

   function automatic void model_release();
      int nxt;
      int t;
      nxt = (m_owner + 1) % N;
      while (prio[0] != nxt) begin
         t = prio.pop_front();
         prio.push_back(t);
      end
      m_owner = -1;
   endfunction

   function automatic void model_step(logic [3:0] v, logic f, logic s);
      bit p;
      bit found;
      if (s) begin
         model_reset();
      end else if (m_owner < 0) begin
         found = 0;
         foreach (prio[k]) begin
            if (!found && v[prio[k]]) begin
               found   = 1;
               m_owner = prio[k];
               m_gid   = prio[k];
               m_words = 0;
            end
         end
      end else begin
         p = v[m_owner] & ~f;
         if (p) m_words++;
         if ((p && m_words == BL) || !v[m_owner]) model_release();
      end
   endfunction

   task automatic step(input logic [3:0] v, input logic f, input logic s,
                       output logic [15:0] act, output logic [15:0] exp);
      @(negedge clk);
      if (fifo_model_en) f = (fifo_occ >= 8);
      req_valid = v;
      fifo_full = f;
      synch_rst = s;
      for (int i = 0; i < N; i++) req_data[i*W +: W] = prod_word[i];
      #1;
      exp = model_out(v, f, s);
      act = {req_ready, fifo_push, fifo_data, grant_valid, grant_id};
      check("outputs", 32'(act), 32'(exp));
      if (fifo_push === 1'b1) push_cnt++;
      if (grant_valid === 1'b1 && prev_gv !== 1'b1) grants.push_back(int'(grant_id));
      prev_gv = grant_valid;
      @(posedge clk);
      for (int i = 0; i < N; i++)
         if (exp[12+i] && v[i]) prod_word[i] = prod_word[i] + 8'd1;
      if (fifo_model_en && exp[11]) fifo_occ++;
      model_step(v, f, s);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      synch_rst = 1'b0;
      req_valid = '0;
      fifo_full = 1'b0;
      req_data = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      model_reset();
      prev_gv = 1'b0;
      push_cnt = 0;
      grants.delete();
      for (int i = 0; i < N; i++) prod_word[i] = 8'(i * 64);
   endtask

   initial begin
      logic [15:0] a, e;
      int gexp [5];
      fifo_model_en = 0;
      fifo_occ = 0;

      // Scenario 1: only producer 2, words 0x10..0x15.
      tbl[0] = '{4'b0100, 1'b0, 1'b0, 16'h0000};
      tbl[1] = '{4'b0100, 1'b0, 1'b0, {4'b0100, 1'b1, 8'h10, 1'b1, 2'd2}};
      tbl[2] = '{4'b0100, 1'b0, 1'b0, {4'b0100, 1'b1, 8'h11, 1'b1, 2'd2}};
      tbl[3] = '{4'b0100, 1'b0, 1'b0, {4'b0100, 1'b1, 8'h12, 1'b1, 2'd2}};
      tbl[4] = '{4'b0100, 1'b0, 1'b0, {4'b0100, 1'b1, 8'h13, 1'b1, 2'd2}};
      tbl[5] = '{4'b0100, 1'b0, 1'b0, {4'b0000, 1'b0, 8'h00, 1'b0, 2'd2}};
      tbl[6] = '{4'b0100, 1'b0, 1'b0, {4'b0100, 1'b1, 8'h14, 1'b1, 2'd2}};
      tbl[7] = '{4'b0100, 1'b0, 1'b0, {4'b0100, 1'b1, 8'h15, 1'b1, 2'd2}};
      tbl[8] = '{4'b0000, 1'b0, 1'b0, {4'b0100, 1'b0, 8'h00, 1'b1, 2'd2}};
      tbl[9] = '{4'b0000, 1'b0, 1'b0, {4'b0000, 1'b0, 8'h00, 1'b0, 2'd2}};

      do_reset();
      step(4'b0000, 1'b0, 1'b0, a, e);
      check("reset_state", 32'(a), 32'h0);
      prod_word[2] = 8'h10;
      for (int i = 0; i < 10; i++) begin
         step(tbl[i].v, tbl[i].f, tbl[i].s, a, e);
         check("table", 32'(a), 32'(tbl[i].exp));
      end

      // Scenario 2a: all producers valid, FIFO never full.
      do_reset();
      for (int i = 0; i < 25; i++) step(4'b1111, 1'b0, 1'b0, a, e);
      gexp = '{0, 1, 2, 3, 0};
      for (int k = 0; k < 5; k++)
         check("grant_order", (k < grants.size()) ? 32'(grants[k]) : 32'hffffffff, 32'(gexp[k]));
      check("pushes_5_grants", 32'(push_cnt), 32'd20);

      // Scenario 2b: depth-8 FIFO with no pops fills after 8 words.
      do_reset();
      fifo_model_en = 1;
      fifo_occ = 0;
      for (int i = 0; i < 20; i++) step(4'b1111, 1'b0, 1'b0, a, e);
      check("pushes_until_full", 32'(push_cnt), 32'd8);
      fifo_model_en = 0;

      // Scenario 3: full for 3 cycles after 2 beats.
      do_reset();
      begin
         logic fp [9];
         fp = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
         for (int i = 0; i < 9; i++) begin
            step(4'b0010, fp[i], 1'b0, a, e);
            if (i >= 3 && i <= 5) check("stall_no_push", 32'({a[15:12], a[11]}), 32'h0);
         end
      end
      check("stall_burst_pushes", 32'(push_cnt), 32'd4);

      // Scenario 4: producer 3 drops valid after 1 beat, producer 0 waiting.
      do_reset();
      step(4'b1000, 1'b0, 1'b0, a, e);
      step(4'b1000, 1'b0, 1'b0, a, e);
      step(4'b0001, 1'b0, 1'b0, a, e);
      step(4'b0001, 1'b0, 1'b0, a, e);
      step(4'b0001, 1'b0, 1'b0, a, e);
      check("wrap_grant", 32'(a[2:0]), 32'({1'b1, 2'd0}));

      // Scenario 5: synch_rst with beat_cnt=2.
      do_reset();
      step(4'b0100, 1'b0, 1'b0, a, e);
      step(4'b0100, 1'b0, 1'b0, a, e);
      step(4'b0100, 1'b0, 1'b0, a, e);
      step(4'b0110, 1'b0, 1'b1, a, e);
      check("srst_no_push", 32'({a[15:12], a[11]}), 32'h0);
      step(4'b0110, 1'b0, 1'b0, a, e);
      check("srst_idle", 32'(a[2]), 32'h0);
      step(4'b0110, 1'b0, 1'b0, a, e);
      check("srst_lowest_grant", 32'(a[2:0]), 32'({1'b1, 2'd1}));

      // Scenario 6: async reset pulse mid-burst.
      do_reset();
      step(4'b0010, 1'b0, 1'b0, a, e);
      step(4'b0010, 1'b0, 1'b0, a, e);
      @(negedge clk);
      #1 reset = 1'b1;
      #1 check("async_rst_outputs",
               32'({req_ready, fifo_push, fifo_data, grant_valid, grant_id}), 32'h0);
      #1 reset = 1'b0;
      model_reset();
      prev_gv = 1'b0;
      @(posedge clk);
      model_step(req_valid, fifo_full, synch_rst);
      step(4'b0010, 1'b0, 1'b0, a, e);
      step(4'b0010, 1'b0, 1'b0, a, e);

      // Randomised traffic against the reference model.
      do_reset();
      for (int i = 0; i < 400; i++) begin
         logic [3:0] v;
         for (int b = 0; b < N; b++) v[b] = ($urandom_range(0, 3) != 0);
         step(v, ($urandom_range(0, 3) == 0), ($urandom_range(0, 49) == 0), a, e);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
